io_handshake_responder: RTL and testbench
=========================================

Name: io_handshake_responder

Overview:
- Device-side endpoint of the processor's 4-phase byte I/O handshake on bus_out/bus_in/hs_out/hs_in.
- Processor writes (p_wr=1) land in an RX FIFO that the device drains.
- Processor reads (p_wr=0) are served from a TX FIFO that the device fills.
- Sits outside the processor at top level; hs_out/p_wr may be asynchronous, so both are synchronized.

Parameters:
D_WIDTH, 8, data byte width
DEPTH, 4, entries per FIFO (power of 2, >=2)
SYNC_STAGES, 2, synchronizer flops on hs_out and p_wr (>=2)

Ports:
g_clk  in  1  clock, rising edge
g_clr  in  1  asynchronous, active-low reset
hs_out  in  1  processor request (level)
p_wr  in  1  1=processor write, 0=processor read; stable while hs_out=1
bus_out  in  D_WIDTH  processor write data; stable while hs_out=1
hs_in  out  1  acknowledge to processor
bus_in  out  D_WIDTH  read data to processor, registered
rx_data  out  D_WIDTH  RX FIFO head (first-word fall-through), valid when rx_empty=0
rx_pop  in  1  pop RX head
rx_empty  out  1  RX FIFO empty
rx_count  out  $clog2(DEPTH)+1  RX occupancy
tx_data  in  D_WIDTH  byte to queue for processor reads
tx_push  in  1  push tx_data
tx_full  out  1  TX FIFO full
tx_count  out  $clog2(DEPTH)+1  TX occupancy
busy  out  1  FSM not in IDLE
drop  out  1  one-cycle pulse: tx_push while full, or rx_pop while empty

Behaviour:
- Reset (g_clr=0, async): hs_in=0, bus_in=0, busy=0, drop=0, both FIFOs empty (rx_empty=1, counts=0, tx_full=0), synchronizers cleared, FSM=IDLE.
- hs_out and p_wr each pass through SYNC_STAGES flops; hs_s and wr_s are the synchronized outputs. Only hs_s/wr_s are used.
- FSM state IDLE, hs_in=0:
  - hs_s=1, wr_s=1, RX not full: push bus_out into RX, hs_in<=1, go ACK.
  - hs_s=1, wr_s=1, RX full: stall in IDLE, hs_in stays 0, no data lost. Proceed once the device pops.
  - hs_s=1, wr_s=0, TX not empty: bus_in<=TX head, pop TX, hs_in<=1 on the same edge, go ACK.
  - hs_s=1, wr_s=0, TX empty: stall in IDLE until a byte is pushed.
- FSM state ACK, hs_in=1: hold hs_in and bus_in until hs_s=0, then hs_in<=0 and go IDLE.
  - Exactly one FIFO transfer per request, regardless of how long hs_out stays high.
- Latency, no stall: hs_in rises SYNC_STAGES+1 rising edges after hs_out rises. hs_in falls SYNC_STAGES+1 edges after hs_out falls.
- bus_in holds its last read value outside transactions and is never updated by writes.
- FIFOs: circular, pointers wrap modulo DEPTH.
- RX simultaneous handshake push and rx_pop:
  - Both occur when non-empty; count unchanged.
  - When full, the stall rule above applies to the push; the pop completes and the push proceeds next cycle.
- TX simultaneous tx_push and handshake pop: both occur; count unchanged.
  - A push to a full TX succeeds if a handshake pop happens the same cycle.
- tx_push while full with no pop: ignored, drop=1 for one cycle. rx_pop while empty: ignored, drop=1.
- Reset mid-transaction:
  - hs_in drops immediately and FIFO contents are lost.
  - If hs_out is still high after release, it is treated as a new request after SYNC_STAGES+1 edges.
- p_wr changing while hs_out=1 is a protocol violation; behaviour is defined only as "ACK completes unchanged".

Test Plan:
- Write: p_wr=1, bus_out=8'hA5, raise hs_out -> hs_in=1 exactly 3 edges later; rx_count=1, rx_data=8'hA5. Drop hs_out -> hs_in=0 3 edges later.
- Read: tx_push 8'h3C then 8'h7E; two read handshakes -> bus_in=8'h3C then 8'h7E, each valid when hs_in rises; tx_count=0 at end.
- RX full stall: 4 writes 8'h01..8'h04 without popping; 5th write 8'h05 -> hs_in stays 0. One rx_pop (data 8'h01) -> hs_in rises; RX holds 02,03,04,05.
- TX empty stall plus simultaneous ops: read request with TX empty -> no hs_in. tx_push 8'h99 -> hs_in rises with bus_in=8'h99. With TX full, tx_push coincident with a handshake pop -> tx_count stays 4, drop=0.
- Errors: tx_push at tx_count=4 with no pop -> drop pulse, count 4, contents unchanged. rx_pop when empty -> drop pulse.
- Reset: assert g_clr=0 while hs_in=1 with RX count 2 -> hs_in=0, bus_in=0, counts 0 asynchronously. Hold hs_out=1 through release -> new ACK 3 edges after reset deasserts.

Source files
------------

// File: rtl/io_handshake_responder.sv
// -----------------------------------------------------------------------------
// io_handshake_responder
//
// Device-side endpoint of the processor's 4-phase byte I/O handshake.
//   Processor writes (p_wr=1) are queued into an RX FIFO drained by the device.
//   Processor reads  (p_wr=0) are served from a TX FIFO filled by the device.
// hs_out and p_wr come from another timing domain and are synchronized first.
//
// Ports
//   g_clk     in   clock, rising edge
//   g_clr     in   asynchronous active-low reset
//   hs_out    in   processor request level (asynchronous)
//   p_wr      in   1=processor write, 0=processor read (asynchronous)
//   bus_out   in   processor write data, stable while hs_out=1
//   hs_in     out  acknowledge to processor
//   bus_in    out  registered read data to processor
//   rx_data   out  RX FIFO head (first-word fall-through)
//   rx_pop    in   pop RX head
//   rx_empty  out  RX FIFO empty
//   rx_count  out  RX occupancy
//   tx_data   in   byte to queue for processor reads
//   tx_push   in   push tx_data
//   tx_full   out  TX FIFO full
//   tx_count  out  TX occupancy
//   busy      out  handshake FSM not idle
//   drop      out  one-cycle pulse on push-to-full / pop-from-empty
// -----------------------------------------------------------------------------
module io_handshake_responder #(
  parameter  int D_WIDTH     = 8,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               hs_out,
  input  logic               p_wr,
  input  logic [D_WIDTH-1:0] bus_out,
  output logic               hs_in,
  output logic [D_WIDTH-1:0] bus_in,
  output logic [D_WIDTH-1:0] rx_data,
  input  logic               rx_pop,
  output logic               rx_empty,
  output logic [CW-1:0]      rx_count,
  input  logic [D_WIDTH-1:0] tx_data,
  input  logic               tx_push,
  output logic               tx_full,
  output logic [CW-1:0]      tx_count,
  output logic               busy,
  output logic               drop
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers for the processor-side request and direction
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_hs_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic                   w_hs_s;
  logic                   w_wr_s;

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      r_hs_sync <= '0;
      r_wr_sync <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value and the shift chain does not collapse.
      r_hs_sync <= {r_hs_sync[SYNC_STAGES-2:0], hs_out};
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], p_wr};
    end
  end

  assign w_hs_s = r_hs_sync[SYNC_STAGES-1];
  assign w_wr_s = r_wr_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [D_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [D_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [AW-1:0]      r_rx_wr, r_rx_rd;
  logic [AW-1:0]      r_tx_wr, r_tx_rd;
  logic [CW-1:0]      r_rx_count, r_tx_count;

  logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic w_rx_push, w_rx_pop;
  logic w_tx_push, w_tx_pop;

  assign w_rx_full  = (r_rx_count == CW'(DEPTH));
  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_full  = (r_tx_count == CW'(DEPTH));
  assign w_tx_empty = (r_tx_count == '0);

  assign w_rx_pop  = rx_pop && !w_rx_empty;
  // A full TX still accepts a push when the handshake frees a slot this cycle.
  assign w_tx_push = tx_push && (!w_tx_full || w_tx_pop);

  // ---------------------------------------------------------------------------
  // Handshake FSM: next state and FIFO strobes
  // ---------------------------------------------------------------------------
  state_t r_state, w_state_nxt;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_rx_push   = 1'b0;
    w_tx_pop    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs_s) begin
          if (w_wr_s) begin
            // Full RX stalls the acknowledge; the write waits for a pop.
            if (!w_rx_full) begin
              w_rx_push   = 1'b1;
              w_state_nxt = ST_ACK;
            end
          end else if (!w_tx_empty) begin
            w_tx_pop    = 1'b1;
            w_state_nxt = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        // One transfer per request: wait here until the request drops.
        if (!w_hs_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic               r_hs_in;
  logic [D_WIDTH-1:0] r_bus_in;
  logic               r_drop;

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      r_state  <= ST_IDLE;
      r_hs_in  <= 1'b0;
      r_bus_in <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hs_in <= (w_state_nxt == ST_ACK);
      if (w_tx_pop) begin
        r_bus_in <= r_tx_mem[r_tx_rd];
      end
      r_drop <= (tx_push && !w_tx_push) || (rx_pop && w_rx_empty);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and occupancy bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CW'(1);
        2'b01:   r_rx_count <= r_rx_count - CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase

      if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CW'(1);
        2'b01:   r_tx_count <= r_tx_count - CW'(1);
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy counters define
  // validity, so clearing them is enough and the arrays map onto plain RAM.
  always_ff @(posedge g_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= bus_out;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hs_in    = r_hs_in;
  assign bus_in   = r_bus_in;
  assign rx_data  = r_rx_mem[r_rx_rd];
  assign rx_empty = w_rx_empty;
  assign rx_count = r_rx_count;
  assign tx_full  = w_tx_full;
  assign tx_count = r_tx_count;
  assign busy     = (r_state != ST_IDLE);
  assign drop     = r_drop;

endmodule

// File: tb/tb_io_handshake_responder.sv
// -----------------------------------------------------------------------------
// tb_io_handshake_responder
//
// Self-checking bench for io_handshake_responder. Expected FIFO contents and
// read data come from queue-based models of the RX and TX FIFOs; handshake
// latencies are measured in clock edges against SYNC_STAGES+1.
// -----------------------------------------------------------------------------
module tb_io_handshake_responder;

  localparam int D_WIDTH     = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic               g_clk;
  logic               g_clr;
  logic               hs_out;
  logic               p_wr;
  logic [D_WIDTH-1:0] bus_out;
  logic               hs_in;
  logic [D_WIDTH-1:0] bus_in;
  logic [D_WIDTH-1:0] rx_data;
  logic               rx_pop;
  logic               rx_empty;
  logic [CW-1:0]      rx_count;
  logic [D_WIDTH-1:0] tx_data;
  logic               tx_push;
  logic               tx_full;
  logic [CW-1:0]      tx_count;
  logic               busy;
  logic               drop;

  io_handshake_responder #(
    .D_WIDTH    (D_WIDTH),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .g_clk   (g_clk),
    .g_clr   (g_clr),
    .hs_out  (hs_out),
    .p_wr    (p_wr),
    .bus_out (bus_out),
    .hs_in   (hs_in),
    .bus_in  (bus_in),
    .rx_data (rx_data),
    .rx_pop  (rx_pop),
    .rx_empty(rx_empty),
    .rx_count(rx_count),
    .tx_data (tx_data),
    .tx_push (tx_push),
    .tx_full (tx_full),
    .tx_count(tx_count),
    .busy    (busy),
    .drop    (drop)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_rd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge g_clk);
  endtask

  // Waits until hs_in reaches the given level; lat = edges taken, -1 on timeout.
  task automatic wait_hs(input logic level, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      if (hs_in === level) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic hs_req(input logic wr, input logic [7:0] d, input int limit, output int lat);
    p_wr    = wr;
    bus_out = d;
    hs_out  = 1'b1;
    wait_hs(1'b1, limit, lat);
  endtask

  task automatic hs_release(input string tag);
    int lat;
    hs_out = 1'b0;
    wait_hs(1'b0, 10, lat);
    check({tag, "_fall_lat"}, lat, LAT);
    check({tag, "_bus_in_hold"}, bus_in, last_rd);
  endtask

  task automatic do_write(input logic [7:0] d);
    int lat;
    hs_req(1'b1, d, 10, lat);
    check("wr_rise_lat", lat, LAT);
    rx_q.push_back(d);
    check("wr_busy", busy, 1);
    check("wr_rx_count", rx_count, rx_q.size());
    check("wr_bus_in_untouched", bus_in, last_rd);
    hs_release("wr");
  endtask

  task automatic do_read();
    int lat;
    logic [7:0] exp;
    hs_req(1'b0, 8'($urandom), 10, lat);
    check("rd_rise_lat", lat, LAT);
    exp     = tx_q.pop_front();
    last_rd = exp;
    check("rd_bus_in", bus_in, exp);
    check("rd_tx_count", tx_count, tx_q.size());
    hs_release("rd");
  endtask

  task automatic do_tx_push(input logic [7:0] d);
    logic exp_drop;
    exp_drop = (tx_q.size() == DEPTH);
    tx_data  = d;
    tx_push  = 1'b1;
    cyc();
    tx_push  = 1'b0;
    if (!exp_drop) tx_q.push_back(d);
    check("tx_push_drop", drop, exp_drop);
    check("tx_push_count", tx_count, tx_q.size());
  endtask

  task automatic do_rx_pop();
    logic       exp_drop;
    logic [7:0] tmp;
    exp_drop = (rx_q.size() == 0);
    if (!exp_drop) check("rx_head", rx_data, rx_q[0]);
    check("rx_empty_flag", rx_empty, exp_drop);
    rx_pop = 1'b1;
    cyc();
    rx_pop = 1'b0;
    if (!exp_drop) tmp = rx_q.pop_front();
    check("rx_pop_drop", drop, exp_drop);
    check("rx_pop_count", rx_count, rx_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] tmp;

    g_clr   = 1'b0;
    hs_out  = 1'b0;
    p_wr    = 1'b0;
    bus_out = '0;
    rx_pop  = 1'b0;
    tx_data = '0;
    tx_push = 1'b0;
    last_rd = '0;
    cyc();
    cyc();
    g_clr = 1'b1;
    cyc();

    // Reset state
    check("rst_hs_in", hs_in, 0);
    check("rst_bus_in", bus_in, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_count", tx_count, 0);

    // Single write of A5
    do_write(8'hA5);
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_rx_empty", rx_empty, 0);
    do_rx_pop();

    // Two reads from TX
    do_tx_push(8'h3C);
    do_tx_push(8'h7E);
    do_read();
    do_read();
    check("rd_tx_empty_end", tx_count, 0);

    // RX full stall
    for (int i = 1; i <= DEPTH; i++) do_write(8'(i));
    check("rx_full_count", rx_count, DEPTH);
    hs_req(1'b1, 8'h05, 8, lat);
    check("rx_full_stall_lat", lat, -1);
    check("rx_full_stall_hs_in", hs_in, 0);
    check("rx_full_stall_busy", busy, 0);
    do_rx_pop();                       // pops 01 while the write waits
    wait_hs(1'b1, 5, lat);
    check("rx_unstall_lat", lat, 1);
    rx_q.push_back(8'h05);
    check("rx_unstall_count", rx_count, rx_q.size());
    hs_release("rx_unstall");
    for (int i = 0; i < DEPTH; i++) do_rx_pop();   // 02,03,04,05

    // TX empty stall
    hs_req(1'b0, 8'h00, 8, lat);
    check("tx_empty_stall_lat", lat, -1);
    check("tx_empty_stall_hs_in", hs_in, 0);
    tx_data = 8'h99;
    tx_push = 1'b1;
    cyc();
    tx_push = 1'b0;
    check("tx_99_drop", drop, 0);
    wait_hs(1'b1, 5, lat);
    check("tx_unstall_lat", lat, 1);
    last_rd = 8'h99;
    check("tx_unstall_bus_in", bus_in, 8'h99);
    check("tx_unstall_count", tx_count, 0);
    hs_release("tx_unstall");

    // Push into full TX on the same edge as a handshake pop
    do_tx_push(8'h11);
    do_tx_push(8'h22);
    do_tx_push(8'h33);
    do_tx_push(8'h44);
    check("tx_full_flag", tx_full, 1);
    p_wr   = 1'b0;
    hs_out = 1'b1;
    for (int i = 1; i < LAT; i++) cyc();
    check("tx_coinc_pre_hs_in", hs_in, 0);
    tx_data = 8'h55;
    tx_push = 1'b1;
    cyc();
    tx_push = 1'b0;
    tmp     = tx_q.pop_front();
    last_rd = tmp;
    tx_q.push_back(8'h55);
    check("tx_coinc_hs_in", hs_in, 1);
    check("tx_coinc_bus_in", bus_in, tmp);
    check("tx_coinc_count", tx_count, DEPTH);
    check("tx_coinc_drop", drop, 0);
    hs_release("tx_coinc");

    // Error pulses
    do_tx_push(8'h66);                 // full, no pop: dropped
    cyc();
    check("tx_drop_one_cycle", drop, 0);
    for (int i = 0; i < DEPTH; i++) do_read();   // 22,33,44,55
    do_rx_pop();                       // RX empty: dropped
    cyc();
    check("rx_drop_one_cycle", drop, 0);

    // Randomized mix against the queue models
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: if (rx_q.size() < DEPTH) do_write(8'($urandom)); else do_rx_pop();
        1: if (tx_q.size() > 0) do_read(); else do_tx_push(8'($urandom));
        2: do_tx_push(8'($urandom));
        default: do_rx_pop();
      endcase
      for (int k = $urandom_range(0, 2); k > 0; k--) cyc();
    end

    // Reset in the middle of a write acknowledge
    while (rx_q.size() > 0) do_rx_pop();
    do_write(8'hC1);
    hs_req(1'b1, 8'hC2, 10, lat);
    check("mid_rst_rise_lat", lat, LAT);
    check("mid_rst_rx_count", rx_count, 2);
    #2;
    g_clr = 1'b0;
    #1;
    rx_q.delete();
    tx_q.delete();
    last_rd = '0;
    check("async_rst_hs_in", hs_in, 0);
    check("async_rst_bus_in", bus_in, 0);
    check("async_rst_rx_count", rx_count, 0);
    check("async_rst_tx_count", tx_count, 0);
    check("async_rst_busy", busy, 0);
    cyc();
    cyc();
    g_clr = 1'b1;                      // hs_out still high: new write request
    wait_hs(1'b1, 10, lat);
    check("post_rst_rise_lat", lat, LAT);
    rx_q.push_back(8'hC2);
    check("post_rst_rx_count", rx_count, rx_q.size());
    check("post_rst_rx_data", rx_data, 8'hC2);
    hs_release("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
